// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock, one block in flight.
// Optional abort input enabled by defining AES_CIPHER_ITER_ABORT_EN.
module aes_cipher_iter #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [127:0]          in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [(NR+1)*128-1:0] w,
  output logic [127:0]          out,
  output logic                  out_valid,
`ifdef AES_CIPHER_ITER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int RCW = $clog2(NR + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (row r, column c) sits at bits [127-8*(4c+r) -: 8].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  logic [1:0]     fsm_q, fsm_d;
  logic [RCW-1:0] rc_q, rc_d;
  logic [127:0]   st_q, st_d;
  logic [127:0]   out_q, out_d;
  logic           ov_q, ov_d;
  logic [127:0]   rkey, ss, mc;

  // Round key selected by the live round counter; w is never latched.
  always_comb begin
    rkey = '0;
    for (int k = 0; k <= NR; k++) begin
      if (rc_q == RCW'(k)) rkey = w[(NR-k)*128 +: 128];
    end
  end

  assign ss = sub_shift(st_q);
  assign mc = mix_columns(ss);

  always_comb begin
    fsm_d = fsm_q;
    rc_d  = rc_q;
    st_d  = st_q;
    out_d = out_q;
    ov_d  = ov_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          st_d  = in ^ w[(NR+1)*128-1 -: 128];
          rc_d  = RCW'(1);
          fsm_d = ROUND;
        end
      end
      ROUND: begin
`ifdef AES_CIPHER_ITER_ABORT_EN
        if (abort) begin
          rc_d  = '0;
          fsm_d = IDLE;
        end else
`endif
        if (rc_q == RCW'(NR)) begin
          out_d = ss ^ rkey;
          ov_d  = 1'b1;
          fsm_d = DONE;
        end else begin
          st_d = mc ^ rkey;
          rc_d = rc_q + RCW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d  = 1'b0;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
      rc_q  <= '0;
      st_q  <= '0;
      out_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      rc_q  <= rc_d;
      st_q  <= st_d;
      out_q <= out_d;
      ov_q  <= ov_d;
    end
  end

  // in_ready is masked by rst so nothing is offered while reset is held.
  assign in_ready  = (fsm_q == IDLE) && !rst;
  assign busy      = (fsm_q == ROUND);
  assign out       = out_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: NR=10/12/14 instances with FIPS-197 vectors.
module tb_aes_cipher_iter;

  localparam logic [127:0] PTA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CTA10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CTA12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CTA14 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, abort;
  logic [127:0] in;
  logic [1407:0] w10;
  logic [1663:0] w12;
  logic [1919:0] w14;
  logic [1919:0] kx;
  logic [1407:0] ka10, kb10;
  logic [127:0] out10, out12, out14;
  logic ov10, ov12, ov14, ir10, ir12, ir14, busy10, busy12, busy14;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_cipher_iter #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(ir10), .w(w10),
    .out(out10), .out_valid(ov10),
`ifdef AES_CIPHER_ITER_ABORT_EN
    .abort(abort),
`endif
    .out_ready(out_ready), .busy(busy10)
  );

  aes_cipher_iter #(.NR(12)) dut12 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(ir12), .w(w12),
    .out(out12), .out_valid(ov12),
`ifdef AES_CIPHER_ITER_ABORT_EN
    .abort(1'b0),
`endif
    .out_ready(out_ready), .busy(busy12)
  );

  aes_cipher_iter #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(ir14), .w(w14),
    .out(out14), .out_valid(ov14),
`ifdef AES_CIPHER_ITER_ABORT_EN
    .abort(1'b0),
`endif
    .out_ready(out_ready), .busy(busy14)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Key schedule built from GF(2^8) arithmetic rather than an S-box table.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gsbox(input logic [7:0] b);
    logic [7:0] v = 8'h01;
    logic [7:0] s;
    if (b == 8'h00) v = 8'h00;
    else for (int i = 0; i < 254; i++) v = gmul(v, b);
    s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {gsbox(x[31:24]), gsbox(x[23:16]), gsbox(x[15:8]), gsbox(x[7:0])};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rcon = 8'h01;
    logic [1919:0] r = '0;
    int total = 4 * (nr + 1);
    for (int i = 0; i < total; i++) begin
      if (i < nk) wd[i] = key[255-32*i -: 32];
      else begin
        t = wd[i-1];
        if (i % nk == 0) begin
          t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        wd[i] = wd[i-nk] ^ t;
      end
      r[(total-1-i)*32 +: 32] = wd[i];
    end
    return r;
  endfunction

  // Accepts one block on dut10, waits for it (bounded) and completes the handshake.
  task automatic block10(input string tag, input logic [127:0] pt, input logic [127:0] exp);
    int lat = -1;
    in = pt;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (ov10) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, 128'(lat), 128'd10);
    check({tag, "_out"}, out10, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_ov_clr"}, 128'(ov10), 128'd0);
    check({tag, "_ir"}, 128'(ir10), 128'd1);
  endtask

  initial begin
    int lat10, lat12, lat14, first, second, seen;
    logic [127:0] ct1, ct2;

    kx = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    ka10 = kx[1407:0];
    kx = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    kb10 = kx[1407:0];
    kx = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    w12 = kx[1663:0];
    kx = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    w14 = kx;
    w10 = ka10;

    rst = 1'b1;
    in = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ir", 128'(ir10), 128'd0);
    check("rst_ov", 128'(ov10), 128'd0);
    check("rst_busy", 128'(busy10), 128'd0);
    check("rst_out", out10, 128'd0);
    rst = 1'b0;
    #1 check("rel_ir", 128'({ir10, ir12, ir14}), 128'd7);

    // Known-answer encryption on all three key sizes, latency counted per instance.
    in = PTA;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in = '1;
    check("busy_after_acc", 128'(busy10), 128'd1);
    check("ir_after_acc", 128'(ir10), 128'd0);
    lat10 = -1;
    lat12 = -1;
    lat14 = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (ov10 && lat10 < 0) lat10 = n;
      if (ov12 && lat12 < 0) lat12 = n;
      if (ov14 && lat14 < 0) lat14 = n;
    end
    check("lat10", 128'(lat10), 128'd10);
    check("lat12", 128'(lat12), 128'd12);
    check("lat14", 128'(lat14), 128'd14);
    check("ct10", out10, CTA10);
    check("ct12", out12, CTA12);
    check("ct14", out14, CTA14);

    // Back-pressure: output must hold and new offers must be ignored.
    for (int i = 0; i < 5; i++) begin
      in = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("hold_out", out10, CTA10);
      check("hold_ov", 128'(ov10), 128'd1);
      check("hold_ir", 128'(ir10), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("hs_ov", 128'({ov10, ov12, ov14}), 128'd0);
    check("hs_ir", 128'(ir10), 128'd1);
    check("hs_busy", 128'(busy10), 128'd0);
    check("hs_out_kept", out10, CTA10);

    // Back-to-back with out_ready tied high; key swapped once block A is out.
    in = PTA;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in = PTB;
    first = -1;
    second = -1;
    ct1 = '0;
    ct2 = '0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (ov10) begin
        if (first < 0) begin
          first = n;
          ct1 = out10;
          w10 = kb10;
        end else if (second < 0) begin
          second = n;
          ct2 = out10;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_first", 128'(first), 128'd10);
    check("b2b_ct1", ct1, CTA10);
    check("b2b_second", 128'(second), 128'd22);
    check("b2b_ct2", ct2, CTB);

    // Reset in the middle of a block (rc = 5).
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    in = PTB;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out", out10, 128'd0);
    check("mid_rst_ov", 128'(ov10), 128'd0);
    check("mid_rst_busy", 128'(busy10), 128'd0);
    check("mid_rst_ir", 128'(ir10), 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (ov10) seen = 1;
    end
    check("rst_no_ov", 128'(seen), 128'd0);
    block10("after_rst", PTB, CTB);

`ifdef AES_CIPHER_ITER_ABORT_EN
    // Abort while rc = 3 drops the block without touching out.
    in = PTA;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", 128'(busy10), 128'd0);
    check("abort_ir", 128'(ir10), 128'd1);
    check("abort_out", out10, CTB);
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (ov10) seen = 1;
    end
    check("abort_no_ov", 128'(seen), 128'd0);
    block10("after_abort", PTB, CTB);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
